// File: rtl/fpu_op_sequencer.sv
// FPU op sequencer: accepts one op, issues it to the datapath, returns flags.
// Optional watchdog on the WAIT state is enabled by defining FPU_SEQ_WDOG_EN.
module fpu_op_sequencer #(
  parameter int TAG_W       = 5,
  parameter int WDOG_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [2:0]       req_rm,
  input  logic [TAG_W-1:0] req_tag,
  input  logic [2:0]       csr_frm,
  output logic             dp_start,
  output logic             dp_kill,
  output logic [2:0]       dp_op,
  output logic [2:0]       dp_rm,
  input  logic             dp_done,
  input  logic [4:0]       dp_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [4:0]       rsp_flags,
  output logic             rsp_illegal,
  output logic [4:0]       fflags,
  input  logic             fflags_clr,
  input  logic             flush,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t     state;
  logic [2:0] rm_res;
  logic       rm_bad;
  logic       accept;
  logic       rsp_hs;
  logic       wdog_fire;

  assign rm_res    = (req_rm == 3'b111) ? csr_frm : req_rm;
  assign rm_bad    = rm_res > 3'b100;
  assign req_ready = rst_n && (state == IDLE) && !flush;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state == RESP) && !flush;
  assign rsp_hs    = rsp_valid && rsp_ready;
  assign busy      = state != IDLE;
  assign dp_start  = (state == ISSUE) && !flush;
  assign dp_kill   = ((state == WAIT) && flush) || wdog_fire;

`ifdef FPU_SEQ_WDOG_EN
  localparam int CW = $clog2(WDOG_CYCLES + 1);

  logic [CW-1:0] wdog;

  assign wdog_fire = (state == WAIT) && !flush && !dp_done
                  && (wdog == CW'(WDOG_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog <= '0;
    end else if (state == ISSUE) begin
      wdog <= '0;
    end else if (state == WAIT) begin
      wdog <= wdog + 1'b1;
    end
  end
`else
  // no watchdog: WAIT holds until dp_done or flush
  assign wdog_fire = WDOG_CYCLES < 0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dp_op       <= '0;
      dp_rm       <= '0;
      rsp_tag     <= '0;
      rsp_flags   <= '0;
      rsp_illegal <= 1'b0;
      fflags      <= '0;
    end else begin
      fflags <= (fflags_clr ? 5'b0 : fflags)
              | (rsp_hs ? rsp_flags : 5'b0);
      if (flush) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (accept) begin
              dp_op       <= req_op;
              dp_rm       <= rm_res;
              rsp_tag     <= req_tag;
              rsp_flags   <= '0;
              rsp_illegal <= rm_bad;
              state       <= rm_bad ? RESP : ISSUE;
            end
          end
          ISSUE: state <= WAIT;
          WAIT: begin
            if (dp_done) begin
              rsp_flags   <= dp_flags;
              rsp_illegal <= 1'b0;
              state       <= RESP;
            end else if (wdog_fire) begin
              rsp_flags   <= 5'b10000;
              rsp_illegal <= 1'b1;
              state       <= RESP;
            end
          end
          RESP: begin
            if (rsp_hs) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Scoreboard bench for fpu_op_sequencer.
// Responses are checked against a queue filled when requests are driven.
module tb_fpu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [2:0] req_rm;
  logic [4:0] req_tag;
  logic [2:0] csr_frm;
  logic       dp_start;
  logic       dp_kill;
  logic [2:0] dp_op;
  logic [2:0] dp_rm;
  logic       dp_done;
  logic [4:0] dp_flags;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [4:0] rsp_tag;
  logic [4:0] rsp_flags;
  logic       rsp_illegal;
  logic [4:0] fflags;
  logic       fflags_clr;
  logic       flush;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [10:0] sb[$];

  always #5 clk = ~clk;

  fpu_op_sequencer #(.TAG_W(5), .WDOG_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rm(req_rm), .req_tag(req_tag),
    .csr_frm(csr_frm),
    .dp_start(dp_start), .dp_kill(dp_kill),
    .dp_op(dp_op), .dp_rm(dp_rm),
    .dp_done(dp_done), .dp_flags(dp_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_tag(rsp_tag), .rsp_flags(rsp_flags),
    .rsp_illegal(rsp_illegal),
    .fflags(fflags), .fflags_clr(fflags_clr),
    .flush(flush), .busy(busy)
  );

  task automatic chk(input string tag, input int unsigned got,
                     input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [2:0] rm,
                      input logic [2:0] frm, input logic [4:0] tag);
    req_valid = 1'b1;
    req_op    = op;
    req_rm    = rm;
    csr_frm   = frm;
    req_tag   = tag;
    #1 chk("req_ready", req_ready, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [10:0] e;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("rsp_tag", rsp_tag, e[10:6]);
        chk("rsp_flags", rsp_flags, e[5:1]);
        chk("rsp_illegal", rsp_illegal, e[0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

  initial begin
    int kill_at;
    rst_n = 0; req_valid = 0; req_op = 0; req_rm = 0; req_tag = 0;
    csr_frm = 0; dp_done = 0; dp_flags = 0; rsp_ready = 1;
    fflags_clr = 0; flush = 0;
    #12;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fflags", fflags, 0);
    chk("rst_dp_start", dp_start, 0);
    chk("rst_rsp_tag", rsp_tag, 0);
    chk("rst_dp_rm", dp_rm, 0);
    rst_n = 1;
    tick();

    // ADD, static rm, one-cycle datapath
    sb.push_back({5'd3, 5'b00001, 1'b0});
    send(3'b000, 3'b000, 3'b000, 5'd3);
    chk("t1_start", dp_start, 1);
    chk("t1_rm", dp_rm, 0);
    tick();
    chk("t1_start_once", dp_start, 0);
    chk("t1_no_kill", dp_kill, 0);
    dp_done = 1; dp_flags = 5'b00001;
    tick();
    dp_done = 0;
    chk("t1_rsp_n3", rsp_valid, 1);
    tick();
    chk("t1_fflags", fflags, 5'b00001);
    chk("t1_idle", busy, 0);

    // dynamic rm resolved from csr_frm
    sb.push_back({5'd4, 5'b00000, 1'b0});
    send(3'b010, 3'b111, 3'b011, 5'd4);
    chk("t2_dp_rm", dp_rm, 3'b011);
    chk("t2_dp_op", dp_op, 3'b010);
    tick();
    dp_done = 1; dp_flags = 0;
    tick();
    dp_done = 0;
    tick();

    // dynamic rm resolving to an illegal mode
    sb.push_back({5'd5, 5'b00000, 1'b1});
    send(3'b010, 3'b111, 3'b101, 5'd5);
    chk("t2i_no_start", dp_start, 0);
    chk("t2i_rsp_n1", rsp_valid, 1);
    chk("t2i_illegal", rsp_illegal, 1);
    tick();
    chk("t2i_idle", busy, 0);

    fflags_clr = 1;
    tick();
    fflags_clr = 0;
    chk("clr_fflags", fflags, 0);

    // back-pressure on the response
    sb.push_back({5'd7, 5'b00100, 1'b0});
    send(3'b000, 3'b001, 3'b000, 5'd7);
    rsp_ready = 0;
    tick();
    dp_done = 1; dp_flags = 5'b00100;
    tick();
    dp_done = 0;
    for (int i = 0; i < 4; i++) begin
      chk("t3_valid", rsp_valid, 1);
      chk("t3_tag", rsp_tag, 7);
      chk("t3_flags", rsp_flags, 5'b00100);
      chk("t3_req_ready", req_ready, 0);
      tick();
    end
    rsp_ready = 1;
    tick();
    chk("t3_idle", busy, 0);
    chk("t3_fflags", fflags, 5'b00100);

    // clear coincident with a handshake keeps only the new flags
    sb.push_back({5'd8, 5'b00010, 1'b0});
    send(3'b011, 3'b010, 3'b000, 5'd8);
    tick();
    dp_done = 1; dp_flags = 5'b00010;
    tick();
    dp_done = 0; fflags_clr = 1;
    tick();
    fflags_clr = 0;
    chk("t5_fflags", fflags, 5'b00010);

    // flush in WAIT, late dp_done ignored
    send(3'b001, 3'b000, 3'b000, 5'd9);
    tick();
    flush = 1;
    #1 chk("t4_kill", dp_kill, 1);
    chk("t4_no_rsp", rsp_valid, 0);
    tick();
    flush = 0; dp_done = 1; dp_flags = 5'b11111;
    #1 chk("t4_idle", busy, 0);
    chk("t4_no_kill", dp_kill, 0);
    tick();
    dp_done = 0;
    chk("t4_still_idle", busy, 0);
    chk("t4_fflags", fflags, 5'b00010);

    // flush in ISSUE suppresses dp_start
    send(3'b100, 3'b000, 3'b000, 5'd10);
    flush = 1;
    #1 chk("fi_no_start", dp_start, 0);
    tick();
    flush = 0;
    chk("fi_idle", busy, 0);

    // reset mid-op: no kill, no response
    send(3'b000, 3'b000, 3'b000, 5'd11);
    tick();
    rst_n = 0;
    #1 chk("rm_no_kill", dp_kill, 0);
    chk("rm_busy", busy, 0);
    chk("rm_no_rsp", rsp_valid, 0);
    chk("rm_fflags", fflags, 0);
    tick();
    rst_n = 1;
    tick();

`ifdef FPU_SEQ_WDOG_EN
    sb.push_back({5'd12, 5'b10000, 1'b1});
    send(3'b000, 3'b000, 3'b000, 5'd12);
    tick();
    kill_at = -1;
    for (int i = 0; i < 10; i++) begin
      if (dp_kill) begin
        kill_at = i;
        break;
      end
      tick();
    end
    chk("wd_kill_at", kill_at, 3);
    tick();
    chk("wd_illegal", rsp_illegal, 1);
    chk("wd_flags", rsp_flags, 5'b10000);
    tick();
    chk("wd_idle", busy, 0);
`else
    kill_at = 0;
    send(3'b000, 3'b000, 3'b000, 5'd12);
    for (int i = 0; i < 100; i++) begin
      if (!busy || dp_kill || rsp_valid) kill_at++;
      tick();
    end
    chk("nowd_hold", kill_at, 0);
    flush = 1;
    tick();
    flush = 0;
    chk("nowd_idle", busy, 0);
`endif

    tick();
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
